// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU data port: one load/store in flight,
// strobe/ack handshake with WAIT_CYCLES wait states and a sticky overrun flag.
module dmem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr_en,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic              overrun
);
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    next_count;
    logic                accept;
    logic                commit;
    logic                wr_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic                commit_wr;
    logic [ADDR_W+1:0]   commit_addr;
    logic [DATA_W-1:0]   commit_wdata;
    logic [ADDR_W-1:0]   commit_idx;
    logic                misaligned;
    logic                unused_alias_bits;

    // Upper address bits are dropped so the array aliases across the 32-bit space.
    assign unused_alias_bits = ^addr[31:ADDR_W+2];

    always_comb begin
        next_state = state;
        next_count = count;
        accept     = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        next_count = CNT_INIT;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (count == '0) begin
                    next_state = RESP;
                end else begin
                    next_count = count - CNT_W'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // With no wait states the commit edge is the accept edge, so use the live inputs.
    assign commit_wr    = (WAIT_CYCLES == 0) ? wr_en : wr_q;
    assign commit_addr  = (WAIT_CYCLES == 0) ? addr[ADDR_W+1:0] : addr_q;
    assign commit_wdata = (WAIT_CYCLES == 0) ? wdata : wdata_q;
    assign commit_idx   = commit_addr[ADDR_W+1:2];
    assign misaligned   = (commit_addr[1:0] != 2'b00);
    assign commit       = (next_state == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            rdata   <= '0;
            err     <= 1'b0;
            overrun <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
            if (accept) begin
                wr_q    <= wr_en;
                addr_q  <= addr[ADDR_W+1:0];
                wdata_q <= wdata;
            end
            if (state == WAIT && req) begin
                overrun <= 1'b1;
            end
            err <= commit && misaligned;
            if (commit && misaligned) begin
                rdata <= '0;
            end else if (commit && !commit_wr) begin
                rdata <= mem[commit_idx];
            end
        end
    end

    // The array is deliberately outside the reset domain; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && commit && commit_wr && !misaligned) begin
            mem[commit_idx] <= commit_wdata;
        end
    end

    assign ack  = (state == RESP);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 instance with directed and random
// traffic, and a WAIT_CYCLES=0 instance driven with back-to-back bursts.
module tb_dmem_responder;
    localparam int W     = 2;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, wr_en;
    logic [31:0] addr, wdata, rdata;
    logic        ack, err, busy, overrun;
    logic        req0, wr_en0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ack0, err0, busy0, overrun0;

    typedef struct {
        int          cyc;
        logic        err;
        bit          chk;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb0[$];
    logic [31:0] mem_m [int];
    logic [31:0] mem0_m [int];
    bit          busy_m [int];
    bit          busy0_m [int];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          next_ok = 0;
    int          ov_at = -1;
    bit          checking = 1'b0;

    dmem_responder #(.WAIT_CYCLES(W), .ADDR_W(AW), .DATA_W(32)) u_dut (
        .clk(clk), .reset(reset), .req(req), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .busy(busy), .overrun(overrun)
    );

    dmem_responder #(.WAIT_CYCLES(0), .ADDR_W(AW), .DATA_W(32)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .wr_en(wr_en0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0), .overrun(overrun0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a strobe is taken only once the previous ack cycle is reached,
    // and its ack lands 1+W cycles later with the result the word array dictates.
    task automatic applyStimulus(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                 input bit abort);
        exp_t        e;
        int unsigned idx;
        req = 1'b1; wr_en = wr; addr = a; wdata = d;
        idx = (a >> 2) % DEPTH;
        if (cyc >= next_ok) begin
            for (int k = cyc + 1; k <= cyc + 1 + W; k++) busy_m[k] = 1'b1;
            next_ok = cyc + 1 + W;
            if (!abort) begin
                e.cyc = next_ok; e.err = (a % 4) != 0; e.chk = 1'b1; e.rdata = '0;
                if (!e.err && wr) begin
                    mem_m[idx] = d;
                    e.chk = 1'b0;
                end else if (!e.err && !mem_m.exists(idx)) begin
                    e.chk = 1'b0;
                end else if (!e.err) begin
                    e.rdata = mem_m[idx];
                end
                sb.push_back(e);
            end
        end else if (ov_at < 0) begin
            ov_at = cyc + 1;
        end
        @(posedge clk); #1;
        req = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic applyStimulus0(input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int unsigned idx;
        req0 = 1'b1; wr_en0 = wr; addr0 = a; wdata0 = d;
        idx = (a >> 2) % DEPTH;
        busy0_m[cyc + 1] = 1'b1;
        e.cyc = cyc + 1; e.err = (a % 4) != 0; e.chk = 1'b1; e.rdata = '0;
        if (!e.err && wr) begin
            mem0_m[idx] = d;
            e.chk = 1'b0;
        end else if (!e.err && !mem0_m.exists(idx)) begin
            e.chk = 1'b0;
        end else if (!e.err) begin
            e.rdata = mem0_m[idx];
        end
        sb0.push_back(e);
        @(posedge clk); #1;
        req0 = 1'b0; wr_en0 = 1'b0; addr0 = '0; wdata0 = '0;
    endtask

    task automatic doReset();
        checking = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = cyc; k <= cyc + W + 2; k++) if (busy_m.exists(k)) busy_m.delete(k);
        busy0_m.delete();
        sb.delete();
        sb0.delete();
        next_ok = cyc;
        ov_at = -1;
        checking = 1'b1;
        @(negedge clk);
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_ack", 32'(ack), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_rdata0", rdata0, 32'h0);
        checkOutput("rst_ack0", 32'(ack0), 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic idleUntilFree();
        while (cyc <= next_ok) idle(1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (checking) begin
            checkOutput("busy", 32'(busy), 32'(busy_m.exists(cyc)));
            checkOutput("overrun", 32'(overrun), 32'(ov_at >= 0 && cyc >= ov_at));
            if (ack) begin
                if (sb.size() == 0) begin
                    checkOutput("ack_unexpected", 32'(ack), 32'h0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("ack_cycle", cyc, e.cyc);
                    checkOutput("err", 32'(err), 32'(e.err));
                    if (e.chk) checkOutput("rdata", rdata, e.rdata);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checkOutput("ack_missing", 32'(ack), 32'h1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (checking) begin
            checkOutput("busy0", 32'(busy0), 32'(busy0_m.exists(cyc)));
            checkOutput("overrun0", 32'(overrun0), 32'h0);
            if (ack0) begin
                if (sb0.size() == 0) begin
                    checkOutput("ack0_unexpected", 32'(ack0), 32'h0);
                end else begin
                    e = sb0.pop_front();
                    checkOutput("ack0_cycle", cyc, e.cyc);
                    checkOutput("err0", 32'(err0), 32'(e.err));
                    if (e.chk) checkOutput("rdata0", rdata0, e.rdata);
                end
            end else if (sb0.size() > 0 && sb0[0].cyc <= cyc) begin
                e = sb0.pop_front();
                checkOutput("ack0_missing", 32'(ack0), 32'h1);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int unsigned idx;
        int unsigned low;
        reset = 1'b1;
        req = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
        req0 = 1'b0; wr_en0 = 1'b0; addr0 = '0; wdata0 = '0;
        repeat (2) @(posedge clk);
        doReset();

        // Store then load the same word.
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        idleUntilFree();
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b0);
        idleUntilFree();

        // Strobe during wait states is dropped and overrun latches.
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h10, 32'h0BAD0BAD, 1'b0);
        idleUntilFree();
        idle(3);

        // Misaligned store: err, rdata cleared, array untouched.
        applyStimulus(1'b1, 32'h13, 32'h12345678, 1'b0);
        idleUntilFree();
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b0);
        idleUntilFree();

        // Upper address bits alias onto word 0.
        applyStimulus(1'b1, 32'h1000, 32'hA5A5A5A5, 1'b0);
        idleUntilFree();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        idleUntilFree();

        // Reset on the commit edge abandons the store.
        applyStimulus(1'b1, 32'h20, 32'h55AA0011, 1'b0);
        idleUntilFree();
        applyStimulus(1'b1, 32'h20, 32'hFFFFFFFF, 1'b1);
        idle(1);
        doReset();
        applyStimulus(1'b0, 32'h20, 32'h0, 1'b0);
        idleUntilFree();

        // Zero-wait instance: back-to-back stores then loads, one ack per cycle.
        for (int i = 0; i < 4; i++) applyStimulus0(1'b1, 32'h40 + 32'(i * 4), 32'hC0DE0000 + 32'(i));
        idle(2);
        for (int i = 0; i < 4; i++) applyStimulus0(1'b0, 32'h40 + 32'(i * 4), 32'h0);
        idle(2);
        for (int i = 0; i < 40; i++) begin
            a = 32'h40 + 32'($urandom_range(0, 7) * 4) + 32'(($urandom_range(0, 5) == 0) ? 2 : 0);
            applyStimulus0(1'($urandom_range(0, 1)), a, $urandom);
            idle($urandom_range(0, 1));
        end
        idle(2);

        // Random mix on the wait-state instance, including aliases, misaligns and drops.
        for (int i = 0; i < 120; i++) begin
            r = $urandom;
            idx = $urandom_range(0, 15);
            low = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            a = (r & ~32'(DEPTH * 4 - 1)) | 32'(idx * 4) | 32'(low);
            case ($urandom_range(0, 7))
                0: ;
                1, 2, 3: while (cyc < next_ok) idle(1);
                default: idle($urandom_range(0, 4));
            endcase
            applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
        end

        for (int k = 0; k < 100 && (sb.size() > 0 || sb0.size() > 0); k++) idle(1);
        checkOutput("drain", 32'(sb.size() + sb0.size()), 32'h0);
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
